// File: rtl/icache_nway_refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_nway_refill_pkg
//  Description : Shared FSM state type and tree pseudo-LRU helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_nway_refill_pkg;

    localparam int PLRU_MAX_LEVELS = 3;
    localparam int PLRU_MAX_NODES  = 7;

    typedef enum logic [2:0] {
        ST_FLUSH    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOOKUP   = 3'd2,
        ST_MISS_REQ = 3'd3,
        ST_REFILL   = 3'd4,
        ST_RESPOND  = 3'd5
    } state_e;

    typedef logic [PLRU_MAX_NODES-1:0] plru_bits_t;

    // Heap-ordered tree: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
    function automatic logic [2:0] plru_victim(input plru_bits_t bits, input int levels);
        logic [2:0] way;
        logic [2:0] node;
        way  = '0;
        node = '0;
        for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                way  = {way[1:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return way;
    endfunction

    function automatic plru_bits_t plru_touch(input plru_bits_t bits, input int levels,
                                              input logic [2:0] way);
        plru_bits_t nb;
        logic [2:0] node;
        logic [2:0] path;
        logic       dir;
        nb   = bits;
        node = '0;
        path = 3'(way << (PLRU_MAX_LEVELS - levels));
        for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
            if (l < levels) begin
                dir      = path[2];
                path     = {path[1:0], 1'b0};
                nb[node] = ~dir;
                node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
            end
        end
        return nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_nway_refill_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_nway_refill_if
//  Description : Fetch, flush and refill-bus signals of the instruction cache.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_nway_refill_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [31:0]       rsp_instr;
    logic              rsp_err;
    logic              flush;
    logic              flush_busy;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    modport slave (
        input  req_valid, req_addr, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output req_ready, rsp_valid, rsp_instr, rsp_err, flush_busy, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  req_ready, rsp_valid, rsp_instr, rsp_err, flush_busy, mem_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_nway_refill_plru.sv
`default_nettype none
// ============================================================================
//  Module      : icache_plru
//  Description : Per-set tree pseudo-LRU state with victim read, touch and clear.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_plru
    import icache_nway_refill_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 128,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  wire logic             clk,
    input  wire logic [IDX_W-1:0] idx,
    output logic      [WAY_W-1:0] victim,
    input  wire logic             touch_en,
    input  wire logic [WAY_W-1:0] touch_way,
    input  wire logic             clr_en,
    input  wire logic [IDX_W-1:0] clr_idx
);
    localparam int LEVELS = $clog2(WAYS);
    localparam int NODES  = (WAYS > 1) ? WAYS - 1 : 1;

    logic [NODES-1:0] plru_mem [SETS];
    plru_bits_t       cur_bits;
    plru_bits_t       new_bits;
    logic [2:0]       victim_full;

    always_comb begin
        cur_bits    = PLRU_MAX_NODES'(plru_mem[idx]);
        victim_full = plru_victim(cur_bits, LEVELS);
        victim      = victim_full[WAY_W-1:0];
        new_bits    = plru_touch(cur_bits, LEVELS, 3'(touch_way));
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            plru_mem[clr_idx] <= '0;
        end else if (touch_en) begin
            plru_mem[idx] <= new_bits[NODES-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/icache_nway_refill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_nway_refill
//  Description : N-way set-associative I-cache with PLRU, burst refill and flush.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_nway_refill
    import icache_nway_refill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    icache_nway_refill_if.slave bus
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [WAY_W-1:0]    victim_q,    victim_d;
    logic [WORD_W-1:0]   cnt_q,       cnt_d;
    logic [IDX_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [31:0]         word_q,      word_d;
    logic                err_q,       err_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;

    logic [IDX_W-1:0]    lat_idx, rd_idx, valid_widx;
    logic [WORD_W-1:0]   lat_word, rd_word;
    logic [TAG_W-1:0]    lat_tag;
    logic [WAYS-1:0]     valid_mem [SETS];
    logic [WAYS-1:0]     valid_row, valid_wrow, match;
    logic [31:0]         data_rd [WAYS];
    logic                valid_we, data_we, tag_we, touch_en, hit, lookup_hit, any_inv;
    logic [WAY_W-1:0]    hit_way, inv_way, plru_way, touch_way;

    assign lat_idx   = addr_q[OFF_W +: IDX_W];
    assign lat_word  = addr_q[2 +: WORD_W];
    assign lat_tag   = addr_q[ADDR_W-1 -: TAG_W];
    // Arrays are read with the incoming address on accept so tags/data land in LOOKUP.
    assign rd_idx    = (state_q == ST_IDLE) ? bus.req_addr[OFF_W +: IDX_W] : lat_idx;
    assign rd_word   = (state_q == ST_IDLE) ? bus.req_addr[2 +: WORD_W]    : lat_word;
    assign valid_row = valid_mem[lat_idx];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0] tag_mem  [SETS];
        logic [31:0]      data_mem [SETS*LINE_WORDS];
        logic [TAG_W-1:0] tag_rd_q;
        logic [31:0]      data_rd_q;

        always_ff @(posedge clk) begin
            if (tag_we && (victim_q == WAY_W'(w))) begin
                tag_mem[lat_idx] <= lat_tag;
            end
            if (data_we && (victim_q == WAY_W'(w))) begin
                data_mem[{lat_idx, cnt_q}] <= bus.mem_rdata;
            end
            tag_rd_q  <= tag_mem[rd_idx];
            data_rd_q <= data_mem[{rd_idx, rd_word}];
        end

        assign match[w]   = valid_row[w] && (tag_rd_q == lat_tag);
        assign data_rd[w] = data_rd_q;
    end

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        any_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_row[w]) begin
                inv_way = WAY_W'(w);
                any_inv = 1'b1;
            end
        end
    end

    assign hit        = |match;
    assign lookup_hit = (state_q == ST_LOOKUP) && hit;

    icache_plru #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_plru (
        .clk       (clk),
        .idx       (lat_idx),
        .victim    (plru_way),
        .touch_en  (touch_en),
        .touch_way (touch_way),
        .clr_en    (state_q == ST_FLUSH),
        .clr_idx   (flush_cnt_q)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        victim_d    = victim_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;
        word_d      = word_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        valid_we    = 1'b0;
        valid_widx  = lat_idx;
        valid_wrow  = valid_row;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        touch_en    = 1'b0;
        touch_way   = hit_way;
        case (state_q)
            ST_FLUSH: begin
                valid_we   = 1'b1;
                valid_widx = flush_cnt_q;
                valid_wrow = '0;
                if (flush_cnt_q == IDX_W'(SETS - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    err_d   = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    touch_en = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    // Victim is invalidated now so an aborted refill never leaves a stale line.
                    victim_d   = any_inv ? inv_way : plru_way;
                    mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d      = '0;
                    valid_we   = 1'b1;
                    valid_wrow = valid_row & ~(WAYS'(1) << victim_d);
                    state_d    = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_err) begin
                        err_d   = 1'b1;
                        state_d = ST_RESPOND;
                    end else begin
                        data_we = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == lat_word) begin
                            word_d = bus.mem_rdata;
                        end
                        if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
                            tag_we     = 1'b1;
                            valid_we   = 1'b1;
                            valid_wrow = valid_row | (WAYS'(1) << victim_q);
                            touch_en   = 1'b1;
                            touch_way  = victim_q;
                            state_d    = ST_RESPOND;
                        end
                    end
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (valid_we) begin
            valid_mem[valid_widx] <= valid_wrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FLUSH;
            addr_q      <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            word_q      <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            victim_q    <= victim_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            word_q      <= word_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.flush_busy = (state_q == ST_FLUSH);
    assign bus.mem_req    = (state_q == ST_MISS_REQ);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.rsp_valid  = lookup_hit || (state_q == ST_RESPOND);
    assign bus.rsp_err    = (state_q == ST_RESPOND) && err_q;
    assign bus.rsp_instr  = lookup_hit                            ? data_rd[hit_way] :
                            ((state_q == ST_RESPOND) && !err_q)   ? word_q           : 32'd0;
endmodule
`default_nettype wire

// File: tb/tb_icache_nway_refill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_nway_refill
//  Description : Directed self-checking bench for icache_nway_refill (4-way, 128 sets, 8 words).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_nway_refill;
    localparam int ADDR_W     = 32;
    localparam int WAYS       = 4;
    localparam int SETS       = 128;
    localparam int LINE_WORDS = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    icache_nway_refill_if #(.ADDR_W(ADDR_W)) bus ();

    icache_nway_refill #(
        .ADDR_W     (ADDR_W),
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready),  32'd0);
        chk({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        chk({tag, "_rsp_instr"},  bus.rsp_instr,       32'd0);
        chk({tag, "_rsp_err"},    32'(bus.rsp_err),    32'd0);
        chk({tag, "_flush_busy"}, 32'(bus.flush_busy), 32'd1);
        chk({tag, "_mem_req"},    32'(bus.mem_req),    32'd0);
        chk({tag, "_mem_addr"},   bus.mem_addr,        32'd0);
    endtask

    // Counts samples with flush_busy high, starting from the current sample.
    task automatic flush_wait(output int cycles, output bit ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (bus.flush_busy && cycles < 400) begin
            cycles++;
            if (bus.req_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // One fetch; a miss is served as a burst of base+k words from this bench.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] base, input int err_beat,
                         input int gnt_dly, input bit gaps, output bit miss,
                         output logic [31:0] instr, output bit err,
                         output logic [31:0] maddr, output bit stable);
        int n;
        miss   = 1'b0;
        instr  = '0;
        err    = 1'b0;
        maddr  = '0;
        stable = 1'b1;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!bus.rsp_valid) begin
            miss = 1'b1;
            @(posedge clk); #1;
            maddr  = bus.mem_addr;
            stable = bus.mem_req;
            for (int d = 0; d < gnt_dly; d++) begin
                @(posedge clk); #1;
                if (!bus.mem_req || (bus.mem_addr !== maddr)) stable = 1'b0;
            end
            bus.mem_gnt = 1'b1;
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                if (gaps) begin
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata  = 32'hDEAD_BEEF;
                    @(posedge clk); #1;
                end
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = base + 32'(k);
                bus.mem_err    = (k == err_beat);
                @(posedge clk); #1;
                if (k == err_beat) break;
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        instr = bus.rsp_instr;
        err   = bus.rsp_err;
    endtask

    bit          miss, err, stable, rdy;
    logic [31:0] instr, maddr;
    int          cyc;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.flush      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        flush_wait(cyc, rdy);
        chk("init_flush_len", 32'(cyc), 32'd128);
        chk("init_flush_ready", 32'(rdy), 32'd0);

        // 1: cold miss then neighbouring-word hit
        fetch(32'h1000, 32'hA0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t1_miss", 32'(miss), 32'd1);
        chk("t1_mem_addr", maddr, 32'h1000);
        chk("t1_instr", instr, 32'hA0);
        chk("t1_err", 32'(err), 32'd0);
        fetch(32'h1004, 32'h0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t1_hit", 32'(miss), 32'd0);
        chk("t1_hit_instr", instr, 32'hA1);

        // 2: set-0 pressure and PLRU eviction
        fetch(32'h0000, 32'h0100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_0000_miss", 32'(miss), 32'd1);
        fetch(32'h1000, 32'h1100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_1000_hit", 32'(miss), 32'd0);
        fetch(32'h2000, 32'h2100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        fetch(32'h3000, 32'h3100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        fetch(32'h4000, 32'h4100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_4000_miss", 32'(miss), 32'd1);
        fetch(32'h0000, 32'h0100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_retouch_miss", 32'(miss), 32'd1);
        fetch(32'h5000, 32'h5100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_5000_miss", 32'(miss), 32'd1);
        fetch(32'h0000, 32'h0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_0000_hit", 32'(miss), 32'd0);
        chk("t2_0000_instr", instr, 32'h0100);
        fetch(32'h1000, 32'h1100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t2_1000_evicted", 32'(miss), 32'd1);
        chk("t2_1000_instr", instr, 32'h1100);

        // 3: bus error on beat 3
        fetch(32'h2010, 32'hC0, 3, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_err_instr", instr, 32'd0);
        fetch(32'h2010, 32'hC0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t3_refetch_miss", 32'(miss), 32'd1);
        chk("t3_refetch_instr", instr, 32'hC4);
        chk("t3_refetch_err", 32'(err), 32'd0);

        // 4: explicit flush
        fetch(32'h3000, 32'h3100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        wait_ready();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        flush_wait(cyc, rdy);
        chk("t4_flush_len", 32'(cyc), 32'd128);
        chk("t4_flush_ready", 32'(rdy), 32'd0);
        fetch(32'h3000, 32'h3100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t4_miss", 32'(miss), 32'd1);

        // 5: delayed grant and gapped beats
        fetch(32'h7008, 32'hE0, -1, 5, 1'b1, miss, instr, err, maddr, stable);
        chk("t5_mem_addr", maddr, 32'h7000);
        chk("t5_stable", 32'(stable), 32'd1);
        chk("t5_instr", instr, 32'hE2);
        fetch(32'h8008, 32'hE0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t5_nogap_instr", instr, 32'hE2);
        fetch(32'h701C, 32'h0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t5_tail_hit", 32'(miss), 32'd0);
        chk("t5_tail_instr", instr, 32'hE7);

        // 6: reset mid-refill
        fetch(32'h1000, 32'h1100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        fetch(32'h1000, 32'h0, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t6_pre_hit", 32'(miss), 32'd0);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h6000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h600 + 32'(k);
            @(posedge clk); #1;
        end
        bus.mem_rdata = 32'h604;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush_wait(cyc, rdy);
        chk("t6_flush_len", 32'(cyc), 32'd128);
        fetch(32'h1000, 32'h1100, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t6_prior_miss", 32'(miss), 32'd1);
        fetch(32'h6000, 32'h600, -1, 0, 1'b0, miss, instr, err, maddr, stable);
        chk("t6_aborted_miss", 32'(miss), 32'd1);
        chk("t6_aborted_instr", instr, 32'h600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
